mac_loop_seq: RTL
=================

MAC_LOOP_SEQ -- requirements
Module: mac_loop_seq

Interface
REQ-001 NB_LOOPS, default 3: number of nested loops; loop 0 is the innermost.
REQ-002 NB_STREAMS, default 2: number of independent address streams.
REQ-003 CNT_WIDTH, default 12: width of each loop counter and range.
REQ-004 ADDR_WIDTH, default 32: width of each stream address.
REQ-005 clk_i  in  1  the single clock; all state is rising-edge.
REQ-006 rst_ni  in  1  asynchronous, active-low reset.
REQ-007 test_mode_i  in  1  test mode; no functional effect.
REQ-008 clear_i  in  1  synchronous soft clear.
REQ-009 start_i  in  1  start pulse; sampled only in IDLE.
REQ-010 range_i  in  NB_LOOPS*CNT_WIDTH  per-loop iteration count; a value of 0 is treated as 1.
REQ-011 base_i  in  NB_STREAMS*ADDR_WIDTH  per-stream start address.
REQ-012 stride_i  in  NB_STREAMS*NB_LOOPS*ADDR_WIDTH  per-stream, per-loop jump stride.
REQ-013 valid_o  out  1  the current step is presented.
REQ-014 ready_i  in  1  the consumer accepts the current step.
REQ-015 addr_o  out  NB_STREAMS*ADDR_WIDTH  current address of each stream.
REQ-016 idx_o  out  NB_LOOPS*CNT_WIDTH  current value of each loop counter.
REQ-017 loop_end_o  out  NB_LOOPS  bit k set when loops 0..k are all at their last value.
REQ-018 last_o  out  1  the current step is the final step.
REQ-019 busy_o  out  1  the FSM is not in IDLE.
REQ-020 done_o  out  1  one-cycle completion pulse.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-022 IDLE->RUN on start_i=1: latch range_i, base_i and stride_i; clear all counters; set addr_o=base_i.
REQ-023 Input changes after start SHALL have no effect until the next start.
REQ-024 valid_o SHALL be 1 exactly while in RUN, first asserting the cycle after start_i.
REQ-025 A step advances only on valid_o&&ready_i; with ready_i=0, all outputs hold stable.
REQ-026 Advance: k = lowest loop index whose counter is not at range-1.
REQ-027 On advance, counter k increments, counters 0..k-1 reset to 0, and each stream s does addr[s] += stride[s][k], wrapping modulo 2^ADDR_WIDTH.
REQ-028 Strides are jump strides: software pre-compensates the rewind of the inner loops.
REQ-029 Completion: last_o = loop_end_o[NB_LOOPS-1]; a handshake with last_o=1 SHALL go RUN->DONE without advancing.
REQ-030 DONE SHALL last exactly one cycle with done_o=1, then go to IDLE.
REQ-031 Total handshakes per run SHALL equal the product of the effective ranges.
REQ-032 An all-ones range SHALL count to 2^CNT_WIDTH-1 with no overflow.
REQ-033 start_i in RUN or DONE SHALL be ignored.
REQ-034 start_i in the same cycle as done_o SHALL be ignored.
REQ-035 clear_i in any state SHALL go to IDLE next cycle with counters and addresses zeroed and no done_o.
REQ-036 clear_i SHALL take priority over start_i and over a handshake.
REQ-037 When all effective ranges are 1, the first step SHALL have last_o=1 and all loop_end_o bits set.
REQ-038 Outputs are registered; there is no combinational path from ready_i or start_i to any output.

Reset
REQ-039 rst_ni=0 SHALL force IDLE immediately and asynchronously.
REQ-040 During reset: valid_o, busy_o, done_o, last_o, loop_end_o, addr_o and idx_o are all 0.
REQ-041 Reset mid-run SHALL abort the run with no done_o.

Verification
REQ-042 NB_LOOPS=2, range=(3,2), base0=0x100, stride0=(4,4), ready tied to 1 -> addr0 sequence 0x100..0x114 in steps of 4, 6 handshakes, last_o on the 6th, done_o one cycle later.
REQ-043 range=(2,2), stride0=(4,-4 in two's complement), base0=0 -> addr0 sequence 0,4,0,4; loop_end_o[0] set on steps 2 and 4.
REQ-044 Random ready_i backpressure -> outputs stable while stalled; sequence identical to the ready=1 run.
REQ-045 clear_i on the 3rd step of a 12-step run -> IDLE next cycle, no done_o; a following start completes all 12 steps.
REQ-046 rst_ni pulsed low mid-run -> all outputs 0 asynchronously, no done_o after release.
REQ-047 All ranges 0 -> one step with last_o=1, loop_end_o all ones; start_i during DONE is ignored.

Source files
------------

// File: rtl/mac_loop_seq.sv
// Nested-loop address sequencer: walks NB_LOOPS nested counters and advances
// NB_STREAMS addresses by per-loop jump strides, one step per valid/ready handshake.
module mac_loop_seq #(
  parameter int unsigned NB_LOOPS   = 3,
  parameter int unsigned NB_STREAMS = 2,
  parameter int unsigned CNT_WIDTH  = 12,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    test_mode_i,
  input  logic                                    clear_i,
  input  logic                                    start_i,
  input  logic [NB_LOOPS*CNT_WIDTH-1:0]           range_i,
  input  logic [NB_STREAMS*ADDR_WIDTH-1:0]        base_i,
  input  logic [NB_STREAMS*NB_LOOPS*ADDR_WIDTH-1:0] stride_i,
  output logic                                    valid_o,
  input  logic                                    ready_i,
  output logic [NB_STREAMS*ADDR_WIDTH-1:0]        addr_o,
  output logic [NB_LOOPS*CNT_WIDTH-1:0]           idx_o,
  output logic [NB_LOOPS-1:0]                     loop_end_o,
  output logic                                    last_o,
  output logic                                    busy_o,
  output logic                                    done_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]                                        r_state,    w_state_n;
  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]                r_last_val, w_last_val_n;
  logic [NB_STREAMS-1:0][NB_LOOPS-1:0][ADDR_WIDTH-1:0] r_stride, w_stride_n;
  logic [NB_STREAMS-1:0][ADDR_WIDTH-1:0]             r_addr,     w_addr_n;
  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]                r_idx,      w_idx_n;
  logic [NB_LOOPS-1:0]                               r_loop_end, w_loop_end_n;
  logic                                              r_valid,    w_valid_n;
  logic                                              r_last,     w_last_n;
  logic                                              r_busy,     w_busy_n;
  logic                                              r_done,     w_done_n;

  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]                w_range;
  logic [NB_STREAMS-1:0][ADDR_WIDTH-1:0]             w_base;
  logic [NB_STREAMS-1:0][NB_LOOPS-1:0][ADDR_WIDTH-1:0] w_stride_in;
  logic                                              w_unused_test_mode;

  assign w_range            = range_i;
  assign w_base             = base_i;
  assign w_stride_in        = stride_i;
  assign w_unused_test_mode = test_mode_i;

  // Next-state and next-output logic; registers hold the stored "last value" = range-1.
  always_comb begin : p_next
    logic v_found;
    logic v_end_acc;
    w_state_n    = r_state;
    w_last_val_n = r_last_val;
    w_stride_n   = r_stride;
    w_addr_n     = r_addr;
    w_idx_n      = r_idx;
    w_valid_n    = r_valid;
    w_done_n     = 1'b0;
    w_loop_end_n = '0;
    v_found      = 1'b0;
    v_end_acc    = 1'b1;

    if (clear_i) begin
      w_state_n = ST_IDLE;
      w_addr_n  = '0;
      w_idx_n   = '0;
      w_valid_n = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            w_state_n  = ST_RUN;
            w_valid_n  = 1'b1;
            w_idx_n    = '0;
            w_addr_n   = w_base;
            w_stride_n = w_stride_in;
            for (int k = 0; k < int'(NB_LOOPS); k++) begin
              w_last_val_n[k] = (w_range[k] == '0) ? '0 : w_range[k] - CNT_WIDTH'(1);
            end
          end
        end
        ST_RUN: begin
          if (ready_i) begin
            if (r_last) begin
              w_state_n = ST_DONE;
              w_valid_n = 1'b0;
              w_done_n  = 1'b1;
            end else begin
              // Lowest non-saturated loop increments; inner loops wrap to zero.
              for (int k = 0; k < int'(NB_LOOPS); k++) begin
                if (!v_found) begin
                  if (r_idx[k] == r_last_val[k]) begin
                    w_idx_n[k] = '0;
                  end else begin
                    w_idx_n[k] = r_idx[k] + CNT_WIDTH'(1);
                    v_found    = 1'b1;
                    for (int s = 0; s < int'(NB_STREAMS); s++) begin
                      w_addr_n[s] = r_addr[s] + r_stride[s][k];
                    end
                  end
                end
              end
            end
          end
        end
        ST_DONE: begin
          w_state_n = ST_IDLE;
        end
        default: begin
          w_state_n = ST_IDLE;
          w_valid_n = 1'b0;
        end
      endcase
    end

    for (int k = 0; k < int'(NB_LOOPS); k++) begin
      v_end_acc       = v_end_acc & (w_idx_n[k] == w_last_val_n[k]);
      w_loop_end_n[k] = v_end_acc & w_valid_n;
    end
    w_last_n = w_loop_end_n[NB_LOOPS-1];
    w_busy_n = (w_state_n != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_last_val <= '0;
      r_stride   <= '0;
      r_addr     <= '0;
      r_idx      <= '0;
      r_loop_end <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_last_val <= w_last_val_n;
      r_stride   <= w_stride_n;
      r_addr     <= w_addr_n;
      r_idx      <= w_idx_n;
      r_loop_end <= w_loop_end_n;
      r_valid    <= w_valid_n;
      r_last     <= w_last_n;
      r_busy     <= w_busy_n;
      r_done     <= w_done_n;
    end
  end

  assign valid_o    = r_valid;
  assign addr_o     = r_addr;
  assign idx_o      = r_idx;
  assign loop_end_o = r_loop_end;
  assign last_o     = r_last;
  assign busy_o     = r_busy;
  assign done_o     = r_done;

endmodule
